nvram_upload: RTL and testbench



---
 rtl/nvram_pkg.sv | 13 +
 rtl/nvram_dirty_tracker.sv | 64 ++++++
 rtl/nvram_upload.sv | 170 +++++++++++++++++
 tb/tb_nvram_upload.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nvram_pkg.sv
// Shared types and constants for the CMOS NVRAM upload path.
package nvram_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWait,
    StHold
  } nvram_state_t;

  localparam logic [7:0] NVRAM_FILL = 8'hFF;

endpackage

// File: rtl/nvram_dirty_tracker.sv
// Tracks CPU writes to CMOS and raises a one-cycle autosave request once the
// game has stopped writing for HOLDOFF_FRAMES vblank periods.
module nvram_dirty_tracker #(
  parameter int unsigned HOLDOFF_FRAMES = 60
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_cmos_we,
  input  logic i_vblank,
  input  logic i_autosave_en,
  input  logic i_upload,
  input  logic i_sel_fall,
  output logic o_upload_req
);

  localparam int unsigned QW = (HOLDOFF_FRAMES < 1) ? 1 : $clog2(HOLDOFF_FRAMES + 1);
  localparam logic [QW-1:0] QuietInit = QW'(HOLDOFF_FRAMES);

  logic          r_vblank_q;
  logic          r_primed;
  logic          r_dirty;
  logic          r_requested;
  logic [QW-1:0] r_quiet;

  logic w_vb_rise;
  logic w_req;

  // r_primed masks the first cycle after reset so it never counts as an edge.
  assign w_vb_rise = i_vblank && !r_vblank_q && r_primed;

  // Combinational so the request can never overlap an active upload.
  assign w_req = (r_quiet == '0) && r_dirty && i_autosave_en && !i_upload && !r_requested;
  assign o_upload_req = w_req;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_vblank_q  <= 1'b0;
      r_primed    <= 1'b0;
      r_dirty     <= 1'b0;
      r_requested <= 1'b0;
      r_quiet     <= QuietInit;
    end else begin
      r_vblank_q <= i_vblank;
      r_primed   <= 1'b1;
      if (i_cmos_we) begin
        // A write beats a simultaneous end-of-session clear and re-arms the request.
        r_dirty     <= 1'b1;
        r_quiet     <= QuietInit;
        r_requested <= 1'b0;
      end else if (i_sel_fall) begin
        r_dirty     <= 1'b0;
        r_requested <= 1'b0;
      end else begin
        if (w_vb_rise && r_dirty && (r_quiet != '0)) begin
          r_quiet <= r_quiet - QW'(1);
        end
        if (w_req) begin
          r_requested <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/nvram_upload.sv
// Serves ioctl upload reads from the CMOS RAM second port, one byte per nibble,
// with a one-deep pending slot for strobes that arrive mid-read.
module nvram_upload
  import nvram_pkg::*;
#(
  parameter int unsigned         ADDR_W         = 10,
  parameter int unsigned         DATA_W         = 4,
  parameter logic [7-DATA_W:0]   PAD            = 4'hF,
  parameter int unsigned         RAM_LATENCY    = 1,
  parameter logic [15:0]         INDEX          = 16'd4,
  parameter int unsigned         HOLDOFF_FRAMES = 60
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic [15:0]       ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_upload_req,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [DATA_W-1:0] ram_q,
  input  logic              cpu_cmos_we,
  input  logic              vblank,
  input  logic              autosave_en,
  output logic              busy,
  output logic              overrun
);

  localparam logic [1:0] LatInit = 2'(RAM_LATENCY);

  nvram_state_t      r_state, w_state_d;
  logic [1:0]        r_cnt, w_cnt_d;
  logic [7:0]        r_din, w_din_d;
  logic [ADDR_W-1:0] r_ram_addr, w_ram_addr_d;
  logic              r_ram_rd, w_ram_rd_d;
  logic              r_pend, w_pend_d;
  logic              r_pend_oor, w_pend_oor_d;
  logic [ADDR_W-1:0] r_pend_addr, w_pend_addr_d;
  logic              r_overrun, w_overrun_d;
  logic              r_sel_q;

  logic              w_sel, w_strobe, w_in_range, w_sel_rise, w_sel_fall;
  logic              w_src_valid, w_src_oor, w_take, w_live_ok;
  logic [ADDR_W-1:0] w_src_addr;

  assign w_sel      = ioctl_upload && (ioctl_index == INDEX);
  assign w_strobe   = w_sel && ioctl_rd;
  assign w_in_range = (ioctl_addr >> ADDR_W) == 25'd0;
  assign w_sel_rise = w_sel && !r_sel_q;
  assign w_sel_fall = !w_sel && r_sel_q;

  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_din_d       = r_din;
    w_ram_addr_d  = r_ram_addr;
    w_ram_rd_d    = 1'b0;
    w_pend_d      = r_pend;
    w_pend_oor_d  = r_pend_oor;
    w_pend_addr_d = r_pend_addr;
    w_overrun_d   = r_overrun;
    w_take        = 1'b0;
    w_live_ok     = 1'b0;
    // A pending strobe is older than a live one, so it is served first.
    w_src_valid   = r_pend || w_strobe;
    w_src_oor     = r_pend ? r_pend_oor : !w_in_range;
    w_src_addr    = r_pend ? r_pend_addr : ioctl_addr[ADDR_W-1:0];

    case (r_state)
      StIdle, StHold: begin
        if (w_src_valid) begin
          w_take    = r_pend;
          w_live_ok = !r_pend;
          if (w_src_oor) begin
            w_din_d   = NVRAM_FILL;
            w_state_d = StHold;
          end else begin
            w_ram_addr_d = w_src_addr;
            w_ram_rd_d   = 1'b1;
            w_cnt_d      = LatInit;
            w_state_d    = StWait;
          end
        end else if ((r_state == StHold) && !w_sel) begin
          w_state_d = StIdle;
        end
      end
      StWait: begin
        if (r_cnt == 2'd0) begin
          w_din_d = {PAD, ram_q};
          // In-range pending reads issue back to back; out-of-range ones go via StHold.
          if (r_pend && !r_pend_oor) begin
            w_take       = 1'b1;
            w_ram_addr_d = r_pend_addr;
            w_ram_rd_d   = 1'b1;
            w_cnt_d      = LatInit;
          end else begin
            w_state_d = StHold;
          end
        end else begin
          w_cnt_d = r_cnt - 2'd1;
        end
      end
      default: w_state_d = StIdle;
    endcase

    if (w_take) begin
      w_pend_d = 1'b0;
    end
    if (w_strobe && !w_live_ok) begin
      if (!r_pend || w_take) begin
        w_pend_d      = 1'b1;
        w_pend_oor_d  = !w_in_range;
        w_pend_addr_d = ioctl_addr[ADDR_W-1:0];
      end else begin
        w_overrun_d = 1'b1;
      end
    end
    if (w_sel_rise) begin
      w_overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state     <= StIdle;
      r_cnt       <= 2'd0;
      r_din       <= 8'h00;
      r_ram_addr  <= '0;
      r_ram_rd    <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_oor  <= 1'b0;
      r_pend_addr <= '0;
      r_overrun   <= 1'b0;
      r_sel_q     <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_din       <= w_din_d;
      r_ram_addr  <= w_ram_addr_d;
      r_ram_rd    <= w_ram_rd_d;
      r_pend      <= w_pend_d;
      r_pend_oor  <= w_pend_oor_d;
      r_pend_addr <= w_pend_addr_d;
      r_overrun   <= w_overrun_d;
      r_sel_q     <= w_sel;
    end
  end

  assign ioctl_din = r_din;
  assign ram_addr  = r_ram_addr;
  assign ram_rd    = r_ram_rd;
  assign overrun   = r_overrun;
  assign busy      = (r_state == StWait) || r_pend;

  nvram_dirty_tracker #(
    .HOLDOFF_FRAMES(HOLDOFF_FRAMES)
  ) u_dirty (
    .i_clk        (clk_sys),
    .i_reset      (reset),
    .i_cmos_we    (cpu_cmos_we),
    .i_vblank     (vblank),
    .i_autosave_en(autosave_en),
    .i_upload     (ioctl_upload),
    .i_sel_fall   (w_sel_fall),
    .o_upload_req (ioctl_upload_req)
  );

endmodule

// File: tb/tb_nvram_upload.sv
// Directed bench: two instances (RAM latency 1 and 3) share one stimulus stream.
module tb_nvram_upload;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_upload;
  logic [15:0] ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic        cpu_cmos_we;
  logic        vblank;
  logic        autosave_en;

  logic [7:0] din1, din3;
  logic       req1, req3;
  logic [9:0] ram_addr1, ram_addr3;
  logic       ram_rd1, ram_rd3;
  logic [3:0] ram_q1, ram_q3;
  logic       busy1, busy3;
  logic       ovr1, ovr3;

  logic [3:0] mem [1024];
  logic [3:0] p1, p3a, p3b, p3c;

  int n_vec = 0;
  int n_err = 0;
  int n_req = 0;
  int n_viol = 0;
  int base;

  always #5 clk_sys = ~clk_sys;

  nvram_upload #(
    .RAM_LATENCY(1),
    .HOLDOFF_FRAMES(2)
  ) dut1 (
    .clk_sys         (clk_sys),
    .reset           (reset),
    .ioctl_upload    (ioctl_upload),
    .ioctl_index     (ioctl_index),
    .ioctl_rd        (ioctl_rd),
    .ioctl_addr      (ioctl_addr),
    .ioctl_din       (din1),
    .ioctl_upload_req(req1),
    .ram_addr        (ram_addr1),
    .ram_rd          (ram_rd1),
    .ram_q           (ram_q1),
    .cpu_cmos_we     (cpu_cmos_we),
    .vblank          (vblank),
    .autosave_en     (autosave_en),
    .busy            (busy1),
    .overrun         (ovr1)
  );

  nvram_upload #(
    .RAM_LATENCY(3),
    .HOLDOFF_FRAMES(2)
  ) dut3 (
    .clk_sys         (clk_sys),
    .reset           (reset),
    .ioctl_upload    (ioctl_upload),
    .ioctl_index     (ioctl_index),
    .ioctl_rd        (ioctl_rd),
    .ioctl_addr      (ioctl_addr),
    .ioctl_din       (din3),
    .ioctl_upload_req(req3),
    .ram_addr        (ram_addr3),
    .ram_rd          (ram_rd3),
    .ram_q           (ram_q3),
    .cpu_cmos_we     (cpu_cmos_we),
    .vblank          (vblank),
    .autosave_en     (autosave_en),
    .busy            (busy3),
    .overrun         (ovr3)
  );

  // CMOS models: data valid RAM_LATENCY cycles after the ram_rd cycle.
  always @(posedge clk_sys) begin
    if (ram_rd1) p1 <= mem[ram_addr1];
    if (ram_rd3) p3a <= mem[ram_addr3];
    p3b <= p3a;
    p3c <= p3b;
  end
  assign ram_q1 = p1;
  assign ram_q3 = p3c;

  always @(posedge clk_sys) begin
    if (req1) n_req <= n_req + 1;
    if ((req1 || req3) && ioctl_upload) n_viol <= n_viol + 1;
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic vb_pulse();
    vblank = 1'b1;
    step();
    vblank = 1'b0;
    step();
    step();
  endtask

  initial begin
    // mem[i] = i ^ 6 (low nibble): mem[5]=3, mem[0]=6, mem[1]=7, mem[2]=4
    for (int i = 0; i < 1024; i++) mem[i] = 4'(i) ^ 4'h6;
    reset = 1'b1;
    ioctl_upload = 1'b0;
    ioctl_index = 16'd4;
    ioctl_rd = 1'b0;
    ioctl_addr = '0;
    cpu_cmos_we = 1'b0;
    vblank = 1'b0;
    autosave_en = 1'b0;
    step();
    step();
    step();
    chk("rst_din", din1, 8'h00);
    chk("rst_ram_rd", ram_rd1, 1'b0);
    chk("rst_ram_addr", ram_addr1, 10'd0);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_overrun", ovr1, 1'b0);
    chk("rst_req", req1, 1'b0);
    reset = 1'b0;
    ioctl_upload = 1'b1;
    step();

    // Basic read, addr 5 -> F3
    ioctl_rd = 1'b1;
    ioctl_addr = 25'd5;
    step();
    ioctl_rd = 1'b0;
    chk("rd_c1_ram_rd", ram_rd1, 1'b1);
    chk("rd_c1_ram_addr", ram_addr1, 10'd5);
    chk("rd_c1_busy", busy1, 1'b1);
    step();
    chk("rd_c2_ram_rd", ram_rd1, 1'b0);
    step();
    chk("rd_c3_din", din1, 8'hF3);
    step();
    chk("rd_c4_din_held", din1, 8'hF3);
    chk("rd_c4_busy", busy1, 1'b0);
    chk("rd_l3_c4_din", din3, 8'h00);
    step();
    chk("rd_l3_c5_din", din3, 8'hF3);
    step();
    step();

    // Out of range
    ioctl_rd = 1'b1;
    ioctl_addr = 25'd1024;
    step();
    ioctl_rd = 1'b0;
    chk("oor_din", din1, 8'hFF);
    chk("oor_ram_rd", ram_rd1, 1'b0);
    step();

    // Wrong index: ignored
    ioctl_index = 16'd0;
    ioctl_rd = 1'b1;
    ioctl_addr = 25'd5;
    step();
    ioctl_rd = 1'b0;
    chk("idx0_din", din1, 8'hFF);
    chk("idx0_ram_rd", ram_rd1, 1'b0);
    chk("idx0_busy", busy1, 1'b0);
    step();
    ioctl_index = 16'd4;
    step();

    // Pending and overrun: strobes at cycles 0,1,2
    ioctl_rd = 1'b1;
    ioctl_addr = 25'd0;
    step();
    chk("pend_c1_ram_rd", ram_rd3, 1'b1);
    chk("pend_c1_ram_addr", ram_addr3, 10'd0);
    ioctl_addr = 25'd1;
    step();
    ioctl_addr = 25'd2;
    step();
    ioctl_rd = 1'b0;
    chk("pend_c3_overrun", ovr3, 1'b1);
    chk("pend_c3_busy", busy3, 1'b1);
    chk("pend_l1_no_overrun", ovr1, 1'b0);
    step();
    chk("pend_c4_ram_rd", ram_rd3, 1'b0);
    step();
    chk("pend_c5_din", din3, 8'hF6);
    chk("pend_c5_ram_rd", ram_rd3, 1'b1);
    chk("pend_c5_ram_addr", ram_addr3, 10'd1);
    step();
    step();
    step();
    step();
    chk("pend_c9_din", din3, 8'hF7);
    chk("pend_c9_busy", busy3, 1'b0);
    step();
    step();
    chk("pend_dropped_din", din3, 8'hF7);
    chk("pend_overrun_sticky", ovr3, 1'b1);
    chk("pend_l1_last_din", din1, 8'hF4);

    // New session clears overrun
    ioctl_upload = 1'b0;
    step();
    ioctl_upload = 1'b1;
    step();
    chk("newsess_overrun", ovr3, 1'b0);
    ioctl_upload = 1'b0;
    step();

    // Autosave disabled: never requested
    base = n_req;
    cpu_cmos_we = 1'b1;
    step();
    cpu_cmos_we = 1'b0;
    vb_pulse();
    vb_pulse();
    vb_pulse();
    chk("as_disabled", n_req - base, 0);

    // Autosave enabled: one request after two frames, no repeat
    cpu_cmos_we = 1'b1;
    step();
    cpu_cmos_we = 1'b0;
    autosave_en = 1'b1;
    base = n_req;
    vb_pulse();
    chk("as_after_1_frame", n_req - base, 0);
    vb_pulse();
    chk("as_after_2_frames", n_req - base, 1);
    vb_pulse();
    vb_pulse();
    vb_pulse();
    chk("as_no_repeat", n_req - base, 1);

    // Write in the same cycle as the session ends: write wins
    ioctl_upload = 1'b1;
    step();
    ioctl_upload = 1'b0;
    cpu_cmos_we = 1'b1;
    step();
    cpu_cmos_we = 1'b0;
    base = n_req;
    vb_pulse();
    chk("race_after_1_frame", n_req - base, 0);
    vb_pulse();
    chk("race_after_2_frames", n_req - base, 1);

    // Session end alone clears dirty
    ioctl_upload = 1'b1;
    step();
    ioctl_upload = 1'b0;
    step();
    base = n_req;
    vb_pulse();
    vb_pulse();
    vb_pulse();
    chk("clear_no_req", n_req - base, 0);

    // Reset in cycle 1 of a read
    ioctl_upload = 1'b1;
    step();
    ioctl_rd = 1'b1;
    ioctl_addr = 25'd5;
    step();
    ioctl_rd = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstmid_din", din1, 8'h00);
    chk("rstmid_ram_rd", ram_rd1, 1'b0);
    chk("rstmid_ram_addr", ram_addr1, 10'd0);
    chk("rstmid_busy", busy1, 1'b0);
    chk("rstmid_busy_l3", busy3, 1'b0);
    chk("rstmid_overrun", ovr1, 1'b0);
    step();
    step();
    step();
    chk("rstmid_no_capture", din1, 8'h00);
    chk("rstmid_no_capture_l3", din3, 8'h00);
    chk("rstmid_ram_rd_idle", ram_rd3, 1'b0);
    ioctl_upload = 1'b0;
    step();
    chk("req_during_upload", n_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
